// File: rtl/arith_pkg.sv
// arith_pkg: shared types and elaboration-time helpers for the segmented
// adder/subtractor.
//   op_e          - operation select encoding carried on the 'sub' input
//   seg_width()   - bits handled by each pipeline segment
//   params_legal()- WIDTH/STAGES combination check used at elaboration
package arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Guarded so an illegal STAGES = 0 never divides by zero before the
    // legality check gets a chance to report it.
    function automatic int seg_width(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        if (stages < 1 || stages > width) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand and result channels of the pipelined
// adder/subtractor, each with a valid/ready handshake.
//   in_valid/in_ready   - operand channel handshake
//   a, b, c_in, sub     - operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready - result channel handshake
//   sum, c_out, ovf     - result, raw carry-out, signed overflow
// master: the side that issues operands and consumes results.
// slave : the arithmetic block itself.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/adder_segment.sv
// adder_segment: W-bit combinational ripple adder built from per-bit full
// adders; one instance per pipeline stage.
//   a, b   - segment operands (b already inverted for subtraction)
//   c_in   - carry into bit 0
//   sum    - segment result
//   c_out  - carry out of the segment MSB
//   c_msb  - carry into the segment MSB (with c_out gives signed overflow)
module adder_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);
    logic [W:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[W];
    assign c_msb = carry[W - 1];
endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit add/subtract split into STAGES ripple
// segments, one segment per clock, with a valid/ready handshake on both sides.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pipelined_add_sub_if.slave (operand and result channels)
// A single global stall (advance) freezes every stage while a result waits
// at the output; bubbles advance like valid slots.
module pipelined_add_sub
    import arith_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_add_sub_if.slave   bus
);
    localparam int SEG_W = seg_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    op_e  op;
    logic advance;

    // Stage inputs (combinational) and stage registers, indexed by stage.
    // acc holds the not-yet-used A segments in its low bits while finished
    // sum segments are shifted in from the top; after the last stage it is
    // exactly the result. opb holds the remaining (possibly inverted) B bits.
    logic             valid_in [STAGES];
    logic             carry_in [STAGES];
    logic [WIDTH-1:0] acc_in   [STAGES];
    logic [WIDTH-1:0] opb_in   [STAGES];

    logic [SEG_W-1:0] seg_sum  [STAGES];
    logic             seg_cout [STAGES];
    logic             seg_cmsb [STAGES];

    logic             valid_q  [STAGES];
    logic             carry_q  [STAGES];
    logic [WIDTH-1:0] acc_q    [STAGES];
    logic [WIDTH-1:0] opb_q    [STAGES];
    logic             ovf_q;

    assign op      = op_e'(bus.sub);
    assign advance = !bus.out_valid || bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtraction is a + ~b + ~borrow_in, so the carry-in is c_in ^ sub.
            assign valid_in[k] = bus.in_valid;
            assign acc_in[k]   = bus.a;
            assign opb_in[k]   = (op == OP_SUB) ? ~bus.b : bus.b;
            assign carry_in[k] = bus.c_in ^ bus.sub;
        end else begin : g_next
            assign valid_in[k] = valid_q[k - 1];
            assign acc_in[k]   = acc_q[k - 1];
            assign opb_in[k]   = opb_q[k - 1];
            assign carry_in[k] = carry_q[k - 1];
        end

        adder_segment #(.W(SEG_W)) u_seg (
            .a     (acc_in[k][SEG_W-1:0]),
            .b     (opb_in[k][SEG_W-1:0]),
            .c_in  (carry_in[k]),
            .sum   (seg_sum[k]),
            .c_out (seg_cout[k]),
            .c_msb (seg_cmsb[k])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset as well as valid bits, so the
            // output pins read all-zero during and right after reset.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                acc_q[k]   <= '0;
                opb_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_in[k];
                carry_q[k] <= seg_cout[k];
                acc_q[k]   <= (acc_in[k] >> SEG_W) | (WIDTH'(seg_sum[k]) << (WIDTH - SEG_W));
                opb_q[k]   <= opb_in[k] >> SEG_W;
            end
            // Only the last segment contains the word MSB.
            ovf_q <= seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = acc_q[STAGES-1];
    assign bus.c_out     = carry_q[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed bench for pipelined_add_sub at WIDTH = 16
// with STAGES = 4, 1 and 16 instantiated side by side, each on its own bus.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pipelined_add_sub;
    localparam int N_DUT = 3;
    localparam int N_VEC = 11;

    function automatic int stg_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c_in;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_c;
        logic        exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid  [N_DUT];
    logic        out_ready [N_DUT];
    logic [15:0] a_i       [N_DUT];
    logic [15:0] b_i       [N_DUT];
    logic        c_in_i    [N_DUT];
    logic        sub_i     [N_DUT];
    logic        in_ready_o  [N_DUT];
    logic        out_valid_o [N_DUT];
    logic [15:0] sum_o       [N_DUT];
    logic        c_out_o     [N_DUT];
    logic        ovf_o       [N_DUT];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N_DUT; i++) begin : g_dut
        pipelined_add_sub_if #(.WIDTH(16)) bus_if ();

        pipelined_add_sub #(.WIDTH(16), .STAGES(stg_of(i))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if)
        );

        assign bus_if.in_valid  = in_valid[i];
        assign bus_if.out_ready = out_ready[i];
        assign bus_if.a         = a_i[i];
        assign bus_if.b         = b_i[i];
        assign bus_if.c_in      = c_in_i[i];
        assign bus_if.sub       = sub_i[i];
        assign in_ready_o[i]    = bus_if.in_ready;
        assign out_valid_o[i]   = bus_if.out_valid;
        assign sum_o[i]         = bus_if.sum;
        assign c_out_o[i]       = bus_if.c_out;
        assign ovf_o[i]         = bus_if.ovf;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference: returns {ovf, c_out, sum}; overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c_in, input logic sub);
        logic [15:0] bb;
        logic [16:0] r;
        logic        v;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + 17'(c_in ^ sub);
        v  = (a[15] == bb[15]) && (r[15] != a[15]);
        return {v, r[16], r[15:0]};
    endfunction

    task automatic drive_op(input int d, input logic [15:0] a, input logic [15:0] b,
                            input logic c_in, input logic sub);
        in_valid[d] = 1'b1;
        a_i[d]      = a;
        b_i[d]      = b;
        c_in_i[d]   = c_in;
        sub_i[d]    = sub;
    endtask

    task automatic run_single(input int d, input int vi, input vec_t v);
        int    n;
        string tag;
        tag = $sformatf("s%0d_vec%0d", stg_of(d), vi);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready_o[d]), 32'd1);
        drive_op(d, v.a, v.b, v.c_in, v.sub);
        @(negedge clk);
        in_valid[d] = 1'b0;
        n = 0;
        while (!out_valid_o[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(stg_of(d) - 1));
        check({tag, "_sum"}, 32'(sum_o[d]), 32'(v.exp_sum));
        check({tag, "_cout_ovf"}, {30'd0, c_out_o[d], ovf_o[d]}, {30'd0, v.exp_c, v.exp_ovf});
        @(negedge clk);
        check({tag, "_once"}, 32'(out_valid_o[d]), 32'd0);
    endtask

    task automatic run_stream(input int d);
        logic [17:0] q[$];
        logic [17:0] e;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int first = -1;
        int last  = -1;
        int got   = 0;
        string tag;
        tag = $sformatf("s%0d_stream", stg_of(d));
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            if (out_valid_o[d]) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check($sformatf("%s_res%0d", tag, got), {14'd0, ovf_o[d], c_out_o[d], sum_o[d]},
                          {14'd0, e});
                end else begin
                    check({tag, "_extra_result"}, 32'd1, 32'd0);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (cyc < 8) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                drive_op(d, ra, rb, rc, rs);
                q.push_back(model(ra, rb, rc, rs));
            end else begin
                in_valid[d] = 1'b0;
            end
        end
        in_valid[d] = 1'b0;
        check({tag, "_count"}, 32'(got), 32'd8);
        check({tag, "_back_to_back"}, 32'(last - first), 32'd7);
    endtask

    task automatic run_backpressure();
        logic [17:0] q[$];
        logic [17:0] e;
        logic [17:0] held;
        logic [15:0] ra, rb;
        int n;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive_op(0, ra, rb, 1'(i & 1), 1'(i >> 1));
            q.push_back(model(ra, rb, 1'(i & 1), 1'(i >> 1)));
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        #1;
        check("bp_in_ready_low", 32'(in_ready_o[0]), 32'd0);
        check("bp_full_valid", 32'(out_valid_o[0]), 32'd1);
        held = {ovf_o[0], c_out_o[0], sum_o[0]};
        check("bp_front", {14'd0, held}, {14'd0, q[0]});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {13'd0, out_valid_o[0], ovf_o[0], c_out_o[0], sum_o[0]},
                  {13'd0, 1'b1, held});
            check($sformatf("bp_in_ready%0d", i), 32'(in_ready_o[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            if (out_valid_o[0]) begin
                e = q.pop_front();
                check($sformatf("bp_drain%0d", n), {14'd0, ovf_o[0], c_out_o[0], sum_o[0]}, {14'd0, e});
            end
            @(negedge clk);
            n++;
        end
        check("bp_drain_cycles", 32'(n), 32'd4);
        check("bp_no_duplicate", 32'(out_valid_o[0]), 32'd0);
    endtask

    task automatic run_reset_midstream(input vec_t v);
        int stale;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_op(0, 16'(16'h1111 * (i + 1)), 16'h0101, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        #1;
        check("rst_pre_valid", 32'(out_valid_o[0]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid_o[0]), 32'd0);
        check("rst_async_data", {14'd0, ovf_o[0], c_out_o[0], sum_o[0]}, 32'd0);
        check("rst_async_in_ready", 32'(in_ready_o[0]), 32'd1);
        @(negedge clk);
        rst          = 1'b0;
        out_ready[0] = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_o[0]) stale++;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        run_single(0, 99, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [N_VEC];
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[5]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        for (int d = 0; d < N_DUT; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            a_i[d]       = '0;
            b_i[d]       = '0;
            c_in_i[d]    = 1'b0;
            sub_i[d]     = 1'b0;
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("s%0d_reset_hs", stg_of(d)), {30'd0, out_valid_o[d], in_ready_o[d]},
                  {30'd0, 1'b0, 1'b1});
            check($sformatf("s%0d_reset_data", stg_of(d)), {14'd0, ovf_o[d], c_out_o[d], sum_o[d]}, 32'd0);
            out_ready[d] = 1'b1;
        end
        rst = 1'b0;

        for (int d = 0; d < N_DUT; d++) begin
            for (int vi = 0; vi < N_VEC; vi++) begin
                run_single(d, vi, vecs[vi]);
            end
            run_stream(d);
        end

        run_backpressure();
        run_reset_midstream(vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
